// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU, memory
// handshake and architectural write strobes, with a memory-wait watchdog.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        Cond_Chk,
  output logic [6:0]  opcode_reg,
  output logic [3:0]  ALUControl_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        retire,
  output logic        illegal,
  output logic        mem_err,
  output logic [3:0]  state_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0]      r_state;
  logic [3:0]      w_state_next;
  logic [TO_W-1:0] r_wdog;
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic            w_legal;
  logic            w_wait_state;
  logic            w_timeout;
  logic            w_unused;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_unused = &{1'b0, instr[31], instr[29:15], instr[11:7]};
  assign w_legal  = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE) || (w_opcode == OP_R) ||
                    (w_opcode == OP_I) || (w_opcode == OP_B) || (w_opcode == OP_JAL);

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // A ready in the terminal cycle still completes the access rather than aborting it.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
                     (r_wdog == TO_W'(MEM_TIMEOUT));

  assign state_o = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_state && !mem_ready && !w_timeout) begin
        r_wdog <= r_wdog + TO_W'(1);
      end else begin
        r_wdog <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) w_state_next = S_DECODE;
        S_DECODE: begin
          case (w_opcode)
            OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
            OP_R:              w_state_next = S_EXECR;
            OP_I:              w_state_next = S_EXECI;
            OP_B:              w_state_next = S_BRANCH;
            OP_JAL:            w_state_next = S_JAL;
            default:           w_state_next = S_FETCH;
          endcase
        end
        S_MEMADR: w_state_next = (w_opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) w_state_next = S_MEMWB;
        S_MEMWB:  w_state_next = S_FETCH;
        S_MEMWR:  if (mem_ready) w_state_next = S_FETCH;
        S_EXECR:  w_state_next = S_ALUWB;
        S_EXECI:  w_state_next = S_ALUWB;
        S_ALUWB:  w_state_next = S_FETCH;
        S_BRANCH: w_state_next = S_FETCH;
        S_JAL:    w_state_next = S_ALUWB;
        default:  w_state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    opcode_reg     = OP_R;
    ALUControl_reg = 4'b0000;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    result_src     = 2'b00;
    adr_src        = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    reg_write      = 1'b0;
    retire         = 1'b0;
    illegal        = 1'b0;
    mem_err        = w_timeout && !rst;
    // Reset and watchdog abort both silence every strobe for the cycle.
    if (!rst && !w_timeout) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          illegal   = !w_legal;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
          retire     = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          retire  = mem_ready;
        end
        S_EXECR: begin
          alu_src_a      = 2'b10;
          opcode_reg     = w_opcode;
          ALUControl_reg = {instr[30], w_f3};
        end
        S_EXECI: begin
          alu_src_a      = 2'b10;
          alu_src_b      = 2'b01;
          opcode_reg     = w_opcode;
          // instr[30] is immediate data except for SRAI.
          ALUControl_reg = {(w_f3 == 3'b101) && instr[30], w_f3};
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a      = 2'b10;
          opcode_reg     = OP_B;
          ALUControl_reg = {1'b1, w_f3};
          pc_write       = Cond_Chk;
          retire         = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: builds the expected per-cycle output trace of
// each instruction from its class and memory wait pattern, then replays and compares.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        Cond_Chk;
  logic [6:0]  opcode_reg;
  logic [3:0]  ALUControl_reg;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic        adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, retire, illegal, mem_err;
  logic [3:0]  state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .Cond_Chk(Cond_Chk),
    .opcode_reg(opcode_reg), .ALUControl_reg(ALUControl_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .adr_src(adr_src), .mem_req(mem_req),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .retire(retire), .illegal(illegal), .mem_err(mem_err), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] op;
    logic [3:0] ac;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic adr, req, we, irw, pcw, rw, ret, ill, err;
  } exp_t;

  exp_t q[$];
  bit   rq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t base(logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    e.op = 7'b0110011;
    return e;
  endfunction

  function automatic bit legal_op(logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  task automatic push(exp_t e, bit rdy);
    q.push_back(e);
    rq.push_back(rdy);
  endtask

  // A memory phase: 'waits' idle cycles then ready; more than TO waits means an abort.
  task automatic mem_phase(exp_t w, exp_t r, int waits, output bit aborted);
    exp_t e;
    aborted = 1'b0;
    if (waits > TO) begin
      for (int i = 0; i < TO; i++) push(w, 1'b0);
      e     = base(w.st);
      e.err = 1'b1;
      push(e, 1'b0);
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) push(w, 1'b0);
      push(r, 1'b1);
    end
  endtask

  task automatic alu_wb();
    exp_t e;
    e     = base(4'd8);
    e.rw  = 1'b1;
    e.ret = 1'b1;
    push(e, 1'($urandom_range(0, 1)));
  endtask

  task automatic build(logic [31:0] ins, int fw, int mw, bit cond);
    exp_t w, r, e;
    bit ab;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    q.delete();
    rq.delete();
    w     = base(4'd0);
    w.req = 1'b1;
    w.b   = 2'b10;
    w.rs  = 2'b10;
    r     = w;
    r.irw = 1'b1;
    r.pcw = 1'b1;
    mem_phase(w, r, fw, ab);
    if (ab) return;
    e     = base(4'd1);
    e.a   = 2'b01;
    e.b   = 2'b01;
    e.ill = !legal_op(opc);
    push(e, 1'($urandom_range(0, 1)));
    case (opc)
      7'b0000011, 7'b0100011: begin
        e   = base(4'd2);
        e.a = 2'b10;
        e.b = 2'b01;
        push(e, 1'($urandom_range(0, 1)));
        if (opc == 7'b0000011) begin
          w     = base(4'd3);
          w.req = 1'b1;
          w.adr = 1'b1;
          mem_phase(w, w, mw, ab);
          if (!ab) begin
            e     = base(4'd4);
            e.rw  = 1'b1;
            e.rs  = 2'b01;
            e.ret = 1'b1;
            push(e, 1'($urandom_range(0, 1)));
          end
        end else begin
          w     = base(4'd5);
          w.req = 1'b1;
          w.we  = 1'b1;
          w.adr = 1'b1;
          r     = w;
          r.ret = 1'b1;
          mem_phase(w, r, mw, ab);
        end
      end
      7'b0110011: begin
        e    = base(4'd6);
        e.a  = 2'b10;
        e.op = opc;
        e.ac = {ins[30], f3};
        push(e, 1'($urandom_range(0, 1)));
        alu_wb();
      end
      7'b0010011: begin
        e    = base(4'd7);
        e.a  = 2'b10;
        e.b  = 2'b01;
        e.op = opc;
        e.ac = {(f3 == 3'b101) && ins[30], f3};
        push(e, 1'($urandom_range(0, 1)));
        alu_wb();
      end
      7'b1100011: begin
        e     = base(4'd9);
        e.a   = 2'b10;
        e.op  = 7'b1100011;
        e.ac  = {1'b1, f3};
        e.pcw = cond;
        e.ret = 1'b1;
        push(e, 1'($urandom_range(0, 1)));
      end
      7'b1101111: begin
        e     = base(4'd10);
        e.a   = 2'b01;
        e.b   = 2'b10;
        e.pcw = 1'b1;
        push(e, 1'($urandom_range(0, 1)));
        alu_wb();
      end
      default: ;
    endcase
  endtask

  task automatic check(exp_t e, string tag);
    logic [29:0] got, ev;
    got = {state_o, opcode_reg, ALUControl_reg, alu_src_a, alu_src_b, result_src, adr_src,
           mem_req, mem_we, ir_write, pc_write, reg_write, retire, illegal, mem_err};
    ev  = e;
    n_tests++;
    assert (got === ev) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, got, ev, state_o, e.st);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic replay(logic [31:0] ins, bit cond, int n, string tag);
    for (int i = 0; i < n && i < q.size(); i++) begin
      instr     = ins;
      Cond_Chk  = cond;
      mem_ready = rq[i];
      @(negedge clk);
      check(q[i], tag);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(logic [31:0] ins, int fw, int mw, bit cond, string tag);
    build(ins, fw, mw, cond);
    replay(ins, cond, q.size(), tag);
    $display("[TB] %s instr=%h fw=%0d mw=%0d cond=%0d cycles=%0d", tag, ins, fw, mw, cond, q.size());
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 32'h0;
    mem_ready = 1'b1;
    Cond_Chk  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check(base(4'd0), "reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(32'h00628333, 0, 0, 1'b0, "add");
    run(32'h40735313, 0, 0, 1'b0, "srai");
    run(32'hFFF00093, 0, 0, 1'b0, "addi_m1");
    run(32'h00208463, 0, 0, 1'b0, "beq_nt");
    run(32'h00208463, 0, 0, 1'b1, "beq_t");
    run(32'h0020C463, 0, 0, 1'b1, "blt");
    run(32'h0000A303, 0, 3, 1'b0, "lw_wait3");
    run(32'h0000A303, 0, TO, 1'b0, "lw_ready_at_limit");
    run(32'h00628333, TO + 1, 0, 1'b0, "fetch_timeout");
    run(32'h0020A023, 0, TO + 1, 1'b0, "sw_timeout");
    run(32'h0000007F, 0, 0, 1'b0, "illegal");
    run(32'h0000006F, 2, 0, 1'b0, "jal");

    build(32'h0020A023, 0, 3, 1'b0);
    replay(32'h0020A023, 1'b0, 4, "sw_pre_rst");
    check(q[3], "memwr_before_rst");
    rst = 1'b1;
    #1;
    check(base(4'd0), "memwr_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset_in_memwr instr=0020a023");
    run(32'h00628333, 1, 0, 1'b0, "add_after_rst");

    for (int k = 0; k < 200; k++) begin
      logic [31:0] ins;
      logic [6:0]  opc;
      int          cls, fw, mw;
      ins = $urandom;
      cls = $urandom_range(0, 6);
      case (cls)
        0: opc = 7'b0000011;
        1: opc = 7'b0100011;
        2: opc = 7'b0110011;
        3: opc = 7'b0010011;
        4: opc = 7'b1100011;
        5: opc = 7'b1101111;
        default: begin
          opc = 7'($urandom);
          while (legal_op(opc)) opc = 7'($urandom);
        end
      endcase
      ins[6:0] = opc;
      fw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO);
      mw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO);
      run(ins, fw, mw, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
